// File: rtl/dp_pkg.sv
// Shared definitions for the bus datapath: ALU op codes, sequencer states and
// the one-hot bus-source encoding.
package dp_pkg;

    localparam int OPC_W = 5;

    localparam logic [OPC_W-1:0] OP_ADD = 5'b00000;
    localparam logic [OPC_W-1:0] OP_SUB = 5'b00001;
    localparam logic [OPC_W-1:0] OP_AND = 5'b00010;
    localparam logic [OPC_W-1:0] OP_OR  = 5'b00011;
    localparam logic [OPC_W-1:0] OP_SHR = 5'b00100;
    localparam logic [OPC_W-1:0] OP_SHL = 5'b00101;
    localparam logic [OPC_W-1:0] OP_ROR = 5'b00110;
    localparam logic [OPC_W-1:0] OP_NOT = 5'b00111;
    localparam logic [OPC_W-1:0] OP_NEG = 5'b01000;
    localparam logic [OPC_W-1:0] OP_MUL = 5'b01001;

    typedef enum logic [2:0] {
        IDLE,
        TY,
        TZ,
        TWB,
        THI,
        DONE
    } state_e;

    localparam int SRC_W = 4;

    localparam logic [SRC_W-1:0] SRC_NONE = 4'b0000;
    localparam logic [SRC_W-1:0] SRC_RB   = 4'b0001;
    localparam logic [SRC_W-1:0] SRC_RC   = 4'b0010;
    localparam logic [SRC_W-1:0] SRC_ZLO  = 4'b0100;
    localparam logic [SRC_W-1:0] SRC_ZHI  = 4'b1000;

    // Each sequencer step owns exactly one bus driver; IDLE and DONE leave it at zero.
    function automatic logic [SRC_W-1:0] bus_src_of(input state_e s);
        case (s)
            TY:      return SRC_RB;
            TZ:      return SRC_RC;
            TWB:     return SRC_ZLO;
            THI:     return SRC_ZHI;
            default: return SRC_NONE;
        endcase
    endfunction

endpackage

// File: rtl/dp_alu.sv
// Combinational bus ALU: Y (a) combined with the bus (b); double-width result so
// the signed multiply keeps its full product.
module dp_alu
    import dp_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OP_W   = OPC_W
) (
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    input  logic [OP_W-1:0]     op,
    output logic [2*DATA_W-1:0] result,
    output logic                illegal
);

    localparam int SH_W = $clog2(DATA_W);

    logic [SH_W-1:0]            sh;
    logic [2*DATA_W-1:0]        rot;
    logic signed [2*DATA_W-1:0] a_ext;
    logic signed [2*DATA_W-1:0] b_ext;
    logic signed [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]          lo;

    assign sh    = b[SH_W-1:0];
    assign rot   = {a, a} >> sh;
    assign a_ext = {{DATA_W{a[DATA_W-1]}}, a};
    assign b_ext = {{DATA_W{b[DATA_W-1]}}, b};
    assign prod  = a_ext * b_ext;

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    always_comb begin
        lo      = '0;
        illegal = 1'b0;
        case (op)
            OP_ADD:  lo = a + b;
            OP_SUB:  lo = a - b;
            OP_AND:  lo = a & b;
            OP_OR:   lo = a | b;
            OP_SHR:  lo = a >> sh;
            OP_SHL:  lo = a << sh;
            OP_ROR:  lo = rot[DATA_W-1:0];
            OP_NOT:  lo = ~b;
            OP_NEG:  lo = -b;
            OP_MUL:  lo = '0;
            default: illegal = 1'b1;
        endcase
        result = (op == OP_MUL) ? prod : {{DATA_W{1'b0}}, lo};
    end

endmodule

// File: rtl/bus_datapath_seq.sv
// Single-bus datapath with register file, Y/Z/HI/LO staging and a micro-sequencer
// that runs Rb->Y, Rc op Y->Z, Z->Ra (plus Z high half->HI for MUL).
module bus_datapath_seq
    import dp_pkg::*;
#(
    parameter int  DATA_W   = 32,
    parameter int  NUM_REGS = 16,
    parameter int  OP_W     = OPC_W,
    localparam int REG_AW   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic [OP_W-1:0]   op_sel,
    input  logic [REG_AW-1:0] ra,
    input  logic [REG_AW-1:0] rb,
    input  logic [REG_AW-1:0] rc,
    input  logic              host_we,
    input  logic [REG_AW-1:0] host_addr,
    input  logic [DATA_W-1:0] host_data,
    output logic [DATA_W-1:0] host_rdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] bus_out,
    output logic [DATA_W-1:0] hi_out,
    output logic [DATA_W-1:0] lo_out
);

    state_e              state_q, state_d;
    logic [OP_W-1:0]     op_q, op_d;
    logic [REG_AW-1:0]   ra_q, ra_d;
    logic [REG_AW-1:0]   rb_q, rb_d;
    logic [REG_AW-1:0]   rc_q, rc_d;
    logic [DATA_W-1:0]   y_q, y_d;
    logic [2*DATA_W-1:0] z_q, z_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic [SRC_W-1:0]    bus_src;
    logic [DATA_W-1:0]   bus;
    logic [2*DATA_W-1:0] alu_result;
    logic                alu_illegal;

    // One-hot AND-OR bus: the step's single source is the only term that survives.
    assign bus_src = bus_src_of(state_q);
    assign bus = ({DATA_W{bus_src[0]}} & regs_q[rb_q])
               | ({DATA_W{bus_src[1]}} & regs_q[rc_q])
               | ({DATA_W{bus_src[2]}} & z_q[DATA_W-1:0])
               | ({DATA_W{bus_src[3]}} & z_q[2*DATA_W-1:DATA_W]);

    dp_alu #(
        .DATA_W (DATA_W),
        .OP_W   (OP_W)
    ) u_alu (
        .a       (y_q),
        .b       (bus),
        .op      (op_q),
        .result  (alu_result),
        .illegal (alu_illegal)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        rc_d    = rc_q;
        y_d     = y_q;
        z_d     = z_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        regs_d  = regs_q;
        err_d   = err_q;

        unique case (state_q)
            IDLE: begin
                if (host_we) begin
                    regs_d[host_addr] = host_data;
                end
                if (start) begin
                    op_d    = op_sel;
                    ra_d    = ra;
                    rb_d    = rb;
                    rc_d    = rc;
                    state_d = TY;
                end
            end
            TY: begin
                y_d     = bus;
                state_d = TZ;
            end
            TZ: begin
                z_d     = alu_result;
                state_d = TWB;
            end
            TWB: begin
                if (alu_illegal) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else if (op_q == OP_MUL) begin
                    lo_d    = bus;
                    state_d = THI;
                end else begin
                    regs_d[ra_q] = bus;
                    state_d      = DONE;
                end
            end
            THI: begin
                hi_d    = bus;
                state_d = DONE;
            end
            DONE: begin
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Status outputs are decoded from the next state so they leave a flop.
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
            op_q    <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            rc_q    <= '0;
            y_q     <= '0;
            z_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            // NOTE: the register file is cleared on reset because software relies on R[i]=0; plain RAM arrays normally skip this.
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            rc_q    <= rc_d;
            y_q     <= y_d;
            z_q     <= z_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            regs_q  <= regs_d;
        end
    end

    assign host_rdata = regs_q[host_addr];
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign bus_out    = bus;
    assign hi_out     = hi_q;
    assign lo_out     = lo_q;

endmodule

// File: tb/tb_bus_datapath_seq.sv
// Directed bench for bus_datapath_seq: hand-computed results, latencies, bus
// sequence, dropped host writes / repeated starts, illegal op and mid-op reset.
module tb_bus_datapath_seq;

    logic        clk = 1'b0;
    logic        clr;
    logic        start;
    logic [4:0]  op_sel;
    logic [3:0]  ra, rb, rc;
    logic        host_we;
    logic [3:0]  host_addr;
    logic [31:0] host_data;
    logic [31:0] host_rdata;
    logic        busy, done, err;
    logic [31:0] bus_out, hi_out, lo_out;

    int checks = 0;
    int errors = 0;

    logic [31:0] bus_trace [1:8];
    int          lat;
    int          pulses;
    logic        err_at_done;
    logic [31:0] rd;

    bus_datapath_seq dut (
        .clk        (clk),
        .clr        (clr),
        .start      (start),
        .op_sel     (op_sel),
        .ra         (ra),
        .rb         (rb),
        .rc         (rc),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_data  (host_data),
        .host_rdata (host_rdata),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .bus_out    (bus_out),
        .hi_out     (hi_out),
        .lo_out     (lo_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [3:0] addr, input logic [31:0] data);
        host_we   = 1'b1;
        host_addr = addr;
        host_data = data;
        tick();
        host_we   = 1'b0;
    endtask

    task automatic read_reg(input logic [3:0] addr, output logic [31:0] data);
        host_addr = addr;
        #1;
        data = host_rdata;
    endtask

    // Runs a fixed 8-cycle window from the start edge, recording bus values,
    // the cycle of the first done pulse and how many done pulses occurred.
    task automatic run_op(input logic [4:0] op, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] c, input bit disturb, input bit pre_we,
                          input logic [3:0] we_addr, input logic [31:0] we_data);
        op_sel    = op;
        ra        = a;
        rb        = b;
        rc        = c;
        start     = 1'b1;
        host_we   = pre_we;
        host_addr = we_addr;
        host_data = we_data;
        lat         = -1;
        pulses      = 0;
        err_at_done = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            bus_trace[i] = bus_out;
            if (done) begin
                pulses++;
                if (lat < 0) begin
                    lat         = i;
                    err_at_done = err;
                end
            end
            if (disturb && i <= 3) begin
                start     = 1'b1;
                host_we   = 1'b1;
                host_addr = 4'd2;
                host_data = 32'd99;
            end else begin
                start   = 1'b0;
                host_we = 1'b0;
            end
        end
    endtask

    logic [4:0]  t_op  [7] = '{5'b00010, 5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000};
    logic [31:0] t_exp [7] = '{32'h0000_0020, 32'h0000_00F5, 32'h0000_000F, 32'h0000_0F10,
                               32'h1000_000F, 32'hFFFF_FFDB, 32'hFFFF_FFDC};
    string       t_tag [7] = '{"and", "or", "shr", "shl", "ror", "not", "neg"};

    initial begin
        clr       = 1'b1;
        start     = 1'b0;
        op_sel    = '0;
        ra        = '0;
        rb        = '0;
        rc        = '0;
        host_we   = 1'b0;
        host_addr = '0;
        host_data = '0;
        tick();
        tick();
        clr = 1'b0;

        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_bus", bus_out, 0);
        check("rst_hi", hi_out, 0);
        check("rst_lo", lo_out, 0);
        read_reg(4'd2, rd);
        check("rst_r2", rd, 0);

        host_write(4'd2, 32'd5);
        host_write(4'd3, 32'd7);

        run_op(5'b00000, 4'd1, 4'd2, 4'd3, 1'b0, 1'b0, 4'd0, 32'd0);
        check("add_lat", lat, 4);
        check("add_pulses", pulses, 1);
        check("add_err", err_at_done, 0);
        read_reg(4'd1, rd);
        check("add_r1", rd, 12);

        run_op(5'b00001, 4'd4, 4'd2, 4'd3, 1'b0, 1'b0, 4'd0, 32'd0);
        check("sub_bus_ty", bus_trace[1], 32'd5);
        check("sub_bus_tz", bus_trace[2], 32'd7);
        check("sub_bus_twb", bus_trace[3], 32'hFFFF_FFFE);
        check("sub_bus_done", bus_trace[4], 32'd0);
        read_reg(4'd4, rd);
        check("sub_r4", rd, 32'hFFFF_FFFE);

        host_write(4'd5, 32'h8000_0000);
        host_write(4'd6, 32'd2);
        run_op(5'b01001, 4'd7, 4'd5, 4'd6, 1'b0, 1'b0, 4'd0, 32'd0);
        check("mul_lat", lat, 5);
        check("mul_pulses", pulses, 1);
        check("mul_lo", lo_out, 32'd0);
        check("mul_hi", hi_out, 32'hFFFF_FFFF);
        check("mul_bus_thi", bus_trace[4], 32'hFFFF_FFFF);
        read_reg(4'd7, rd);
        check("mul_r7", rd, 0);
        read_reg(4'd5, rd);
        check("mul_r5", rd, 32'h8000_0000);

        run_op(5'b00000, 4'd8, 4'd2, 4'd3, 1'b1, 1'b0, 4'd0, 32'd0);
        check("busy_pulses", pulses, 1);
        check("busy_lat", lat, 4);
        read_reg(4'd2, rd);
        check("busy_r2_kept", rd, 5);
        read_reg(4'd8, rd);
        check("busy_r8", rd, 12);

        run_op(5'b11111, 4'd1, 4'd2, 4'd3, 1'b0, 1'b0, 4'd0, 32'd0);
        check("ill_lat", lat, 4);
        check("ill_err", err_at_done, 1);
        check("ill_err_clear", err, 0);
        read_reg(4'd1, rd);
        check("ill_r1", rd, 12);

        run_op(5'b00000, 4'd2, 4'd2, 4'd2, 1'b0, 1'b0, 4'd0, 32'd0);
        read_reg(4'd2, rd);
        check("alias_r2", rd, 10);

        host_write(4'd12, 32'h0000_00F1);
        host_write(4'd13, 32'h0000_0024);
        for (int k = 0; k < 7; k++) begin
            run_op(t_op[k], 4'd14, 4'd12, 4'd13, 1'b0, 1'b0, 4'd0, 32'd0);
            read_reg(4'd14, rd);
            check(t_tag[k], rd, t_exp[k]);
        end

        run_op(5'b00000, 4'd10, 4'd9, 4'd3, 1'b0, 1'b1, 4'd9, 32'd40);
        check("same_cycle_bus", bus_trace[1], 32'd40);
        read_reg(4'd10, rd);
        check("same_cycle_r10", rd, 47);

        op_sel = 5'b00000;
        ra     = 4'd11;
        rb     = 4'd2;
        rc     = 4'd3;
        start  = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("abort_busy_tz", busy, 1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("abort_idle", busy, 0);
        check("abort_done", done, 0);
        check("abort_hi", hi_out, 0);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done) pulses++;
        end
        check("abort_no_done", pulses, 0);
        read_reg(4'd2, rd);
        check("abort_r2", rd, 0);
        read_reg(4'd11, rd);
        check("abort_r11", rd, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
